// File: rtl/twos_pkg.sv
// Shared definitions for the two's-complement to sign-magnitude serial decoder.
//   dec_state_t : decoder FSM states
//   TWOS_W      : default word width
package twos_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } dec_state_t;

  localparam int unsigned TWOS_W = 4;

endpackage

// File: rtl/twos_signmag_decoder_if.sv
// Handshake bundle for twos_signmag_decoder.
//   Input channel : in_data, in_valid (to decoder), in_ready (from decoder)
//   Output channel: out_sign, out_mag, out_valid (from decoder), out_ready (to decoder)
//   slave  modport: decoder side
//   master modport: producer/consumer environment side
interface twos_signmag_decoder_if
  import twos_pkg::*;
#(
  parameter int unsigned W = TWOS_W
) ();

  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         out_sign;
  logic [W-1:0] out_mag;
  logic         out_valid;
  logic         out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_sign,
    output out_mag,
    output out_valid
  );

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_sign,
    input  out_mag,
    input  out_valid
  );

endinterface

// File: rtl/twos_serial_cell.sv
// Serial two's-complement negation cell, LSB first, copy-until-first-one rule.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   b_i        : current input bit
//   neg_i      : word is negative (negate it)
//   clear_i    : start of a new word, forget any seen one
//   en_i       : a bit is being processed this cycle
//   bit_o      : output bit (combinational from b_i and stored flag)
module twos_serial_cell (
  input  logic clk,
  input  logic rst,
  input  logic b_i,
  input  logic neg_i,
  input  logic clear_i,
  input  logic en_i,
  output logic bit_o
);

  logic seen_one_q;

  // Bits up to and including the first one pass through; later bits invert.
  assign bit_o = b_i ^ (neg_i & seen_one_q);

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      seen_one_q <= 1'b0;
    end else if (en_i && neg_i && b_i) begin
      seen_one_q <= 1'b1;
    end
  end

endmodule

// File: rtl/twos_signmag_decoder.sv
// Bit-serial decoder from W-bit two's-complement words to sign-magnitude.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : handshake bundle (slave side), see twos_signmag_decoder_if
// A word is accepted in IDLE, negated (if negative) one bit per cycle in SHIFT,
// then held in DONE until the consumer takes it. All outputs come from flops.
module twos_signmag_decoder
  import twos_pkg::*;
#(
  parameter int unsigned W = TWOS_W
) (
  input logic                   clk,
  input logic                   rst,
  twos_signmag_decoder_if.slave bus
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  dec_state_t      state_q;
  logic [CntW-1:0] cnt_q;
  logic [W-1:0]    shreg_q;
  logic [W-1:0]    mag_q;
  logic            sign_q;
  logic            in_ready_q;
  logic            out_valid_q;

  logic accept;
  logic shifting;
  logic cell_bit;

  assign accept   = (state_q == StIdle) && bus.in_valid;
  assign shifting = (state_q == StShift);

  twos_serial_cell u_cell (
    .clk     (clk),
    .rst     (rst),
    .b_i     (shreg_q[0]),
    .neg_i   (sign_q),
    .clear_i (accept),
    .en_i    (shifting),
    .bit_o   (cell_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shreg_q     <= '0;
      mag_q       <= '0;
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            shreg_q    <= bus.in_data;
            sign_q     <= bus.in_data[W-1];
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StShift;
          end
        end
        StShift: begin
          // Magnitude fills from the top; after W bits the LSB lands at bit 0.
          mag_q   <= {cell_bit, mag_q[W-1:1]};
          shreg_q <= shreg_q >> 1;
          if (cnt_q == CntLast) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sign  = sign_q;
  assign bus.out_mag   = mag_q;

endmodule

// File: tb/tb_twos_signmag_decoder.sv
// Self-checking bench for twos_signmag_decoder: W=4 directed cases and a W=8 full sweep,
// results checked against a scoreboard filled from an arithmetic reference model.
module tb_twos_signmag_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  twos_signmag_decoder_if #(.W(4)) if4 ();
  twos_signmag_decoder_if #(.W(8)) if8 ();

  twos_signmag_decoder #(.W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  twos_signmag_decoder #(.W(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [4:0] q4[$];
  logic [8:0] q8[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: sign = MSB, magnitude = |value| modulo 2^W.
  function automatic logic [4:0] ref4(input logic [3:0] d);
    logic [3:0] m;
    m = d[3] ? (4'd0 - d) : d;
    return {d[3], m};
  endfunction

  function automatic logic [8:0] ref8(input logic [7:0] d);
    logic [7:0] m;
    m = d[7] ? (8'd0 - d) : d;
    return {d[7], m};
  endfunction

  // Scoreboard consumers: a result is taken where out_valid & out_ready are both high.
  always @(negedge clk) begin
    if (!rst && if4.out_valid && if4.out_ready) begin
      check("w4_pending", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) check("w4_result", {if4.out_sign, if4.out_mag}, q4.pop_front());
    end
    if (!rst && if8.out_valid && if8.out_ready) begin
      check("w8_pending", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) check("w8_result", {if8.out_sign, if8.out_mag}, q8.pop_front());
    end
  end

  // W=8 consumer applies random backpressure.
  always @(posedge clk) begin
    #1;
    if8.out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send4(input logic [3:0] d);
    int n = 0;
    while (!if4.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("w4_send_wait", 32'(n < 100), 32'd1);
    if4.in_data  = d;
    if4.in_valid = 1'b1;
    q4.push_back(ref4(d));
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    if4.in_data  = 4'($urandom);
  endtask

  task automatic send8(input logic [7:0] d);
    int n = 0;
    while (!if8.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("w8_send_wait", 32'(n < 100), 32'd1);
    if8.in_data  = d;
    if8.in_valid = 1'b1;
    q8.push_back(ref8(d));
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    if8.in_data  = 8'($urandom);
  endtask

  task automatic drain4();
    int n = 0;
    while ((q4.size() != 0 || !if4.in_ready) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("w4_drain", 32'(n < 200), 32'd1);
  endtask

  task automatic drain8();
    int n = 0;
    while ((q8.size() != 0 || !if8.in_ready) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("w8_drain", 32'(n < 200), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] seq[4];
    int         n;

    if4.in_data   = '0;
    if4.in_valid  = 1'b0;
    if4.out_ready = 1'b1;
    if8.in_data   = '0;
    if8.in_valid  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", if4.in_ready, 1);
    check("rst_out_valid", if4.out_valid, 0);
    check("rst_out_sign", if4.out_sign, 0);
    check("rst_out_mag", if4.out_mag, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Latency: the accept cycle begins at edge k; out_valid must rise at edge k+W+1.
    if4.in_data  = 4'b0101;
    if4.in_valid = 1'b1;
    q4.push_back(ref4(4'b0101));
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("lat_early", if4.out_valid, 0);
    @(posedge clk); #1;
    check("lat_on", if4.out_valid, 1);
    check("lat_busy", if4.in_ready, 0);
    @(posedge clk); #1;
    check("lat_one_cycle", if4.out_valid, 0);
    check("lat_rdy_back", if4.in_ready, 1);

    seq = '{4'b1011, 4'b1111, 4'b1000, 4'b0000};
    foreach (seq[i]) send4(seq[i]);
    drain4();

    // Backpressure: result held 6 cycles while a second word is offered and ignored.
    if4.out_ready = 1'b0;
    send4(4'b1011);
    n = 0;
    while (!if4.out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("hold_reach_done", 32'(n < 50), 32'd1);
    for (int c = 0; c < 6; c++) begin
      if4.in_data  = 4'b0110;
      if4.in_valid = 1'b1;
      check("hold_valid", if4.out_valid, 1);
      check("hold_result", {if4.out_sign, if4.out_mag}, 5'b1_0101);
      check("hold_in_ready", if4.in_ready, 0);
      @(posedge clk); #1;
    end
    if4.out_ready = 1'b1;
    q4.push_back(ref4(4'b0110));
    @(posedge clk); #1;
    check("rel_idle", if4.in_ready, 1);
    @(posedge clk); #1;
    check("rel_accept", if4.in_ready, 0);
    if4.in_valid = 1'b0;
    drain4();

    // Reset during the second SHIFT cycle of 1011; no result may appear for it.
    if4.in_data  = 4'b1011;
    if4.in_valid = 1'b1;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", if4.in_ready, 1);
    check("abort_out_valid", if4.out_valid, 0);
    check("abort_out_sign", if4.out_sign, 0);
    check("abort_out_mag", if4.out_mag, 0);
    send4(4'b0011);
    drain4();

    for (int i = 0; i < 256; i++) send8(8'(i));
    drain8();

    check("queues_empty", 32'(q4.size() + q8.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/twos_signmag_decoder.md
# twos_signmag_decoder

Bit-serial decoder from W-bit two's-complement words to sign-magnitude form. It sits downstream of the parallel two's-complement negation logic in the arithmetic datapath and recovers `sign` and `|value|` for display and compare stages. Negative words are negated one bit per cycle, LSB first, with the copy-until-first-one rule. Words enter and leave through valid/ready handshakes.

## Interface
Parameters:
- `W` — default 4 — word width in bits; legal range W ≥ 2.

Ports:
- `clk` — in — 1 — single clock; all state changes on the rising edge.
- `rst` — in — 1 — reset, synchronous and active-high.
- `in_data` — in — W — two's-complement word; bit W-1 is the sign.
- `in_valid` — in — 1 — `in_data` is valid.
- `in_ready` — out — 1 — block can accept a word (high only in IDLE).
- `out_sign` — out — 1 — 1 when the accepted word was negative.
- `out_mag` — out — W — unsigned magnitude. Covers −2^(W-1), which gives 2^(W-1).
- `out_valid` — out — 1 — `out_sign`/`out_mag` are valid.
- `out_ready` — in — 1 — consumer takes the result.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE. Reset places it in IDLE.
- **IDLE:** `in_ready`=1.
  - On `in_valid`&`in_ready`: latch `in_data` into the shift register and `in_data[W-1]` into the sign register.
  - Clear the bit counter and the `seen_one` flag, then go to SHIFT.
- **SHIFT:** each cycle, process bit b = `shreg[0]`, then shift `shreg` right.
  - Sign 0: out bit = b.
  - Sign 1, `seen_one`=0: out bit = b; set `seen_one` if b=1.
  - Sign 1, `seen_one`=1: out bit = ~b.
  - The out bit enters the magnitude register at bit W-1; the register shifts right. After W bits the LSB sits at bit 0.
  - When counter = W-1, go to DONE. Otherwise increment the counter.
- **DONE:** `out_valid`=1; `out_sign`/`out_mag` are held stable.
  - On `out_ready`, go to IDLE.
  - `out_valid` drops on the next edge.
- Input rules:
  - `in_valid` outside IDLE is ignored and its data is not captured. The source must hold the word until `in_ready`.
  - `in_data` may change freely after acceptance.
- Arithmetic:
  - Magnitude is computed modulo 2^W with no overflow flag.
  - 0 → sign 0, magnitude 0.
  - Most-negative word → sign 1, magnitude 1 followed by W-1 zeros.
- Reset in any state, including mid-SHIFT or in DONE with a result pending:
  - Next state is IDLE, `out_valid`=0, `out_sign`=0, `out_mag`=0, counter=0, `seen_one`=0.
  - The word in progress is discarded.

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `out_sign`=0, `out_mag`=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_*` to `out_*`, or from `out_ready` to `in_ready`.
- Latency: accept on edge k → `out_valid`=1 from edge k+W+1.
- Minimum word period is W+2 cycles: 1 cycle to accept, W to shift, ≥1 in DONE.
- `out_ready` held high while entering DONE → result is visible for exactly 1 cycle; `in_ready` returns on the following edge.
- There is no same-cycle IDLE re-accept in DONE, because `in_ready`=0 throughout SHIFT and DONE.

## Structure
- Shared package `twos_pkg` holds:
  - the state enum `dec_state_t` {IDLE, SHIFT, DONE};
  - default width constant `TWOS_W = 4`;
  - counter width `$clog2(W)`, computed in the block from `W`.
- One natural sub-module: `twos_serial_cell`. It holds `seen_one` and the invert decision, with inputs b, `neg`, `clear`, `en` and output the bit. The same cell is reused by a future serial encoder.
- Top level contains the FSM, counter, shift register and magnitude register.

## Test plan
- W=4, 0101 accepted, `out_ready`=1 → `out_valid` on edge k+5, sign 0, mag 0101.
- 1011 (−5) → sign 1, mag 0101. 1111 (−1) → sign 1, mag 0001.
- 1000 (−8) → sign 1, mag 1000. 0000 → sign 0, mag 0000.
- `out_ready` low 6 cycles in DONE → outputs stable and `in_ready`=0 throughout. Second word presented meanwhile is not captured. On release, result is taken and the next word is accepted 1 cycle later.
- `rst` pulsed on the 2nd SHIFT cycle of 1011 → next cycle IDLE with all outputs 0. Then 0011 → sign 0, mag 0011, with no residue from the aborted word.
- W=8 sweep of all 256 inputs against a reference model (sign = MSB, mag = abs mod 256) → all match.
